// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, instruction register and an 8-deep circular
// return stack with sticky overflow/underflow flags.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_incr_en,
  input  logic        pc_j_en,
  input  logic        pc_call_en,
  input  logic        pc_ret_en,
  input  logic        instr_rd_en,
  input  logic        instr_flush,
  input  logic [4:0]  pclath,
  input  logic [13:0] prog_mem_data,
  output logic [12:0] prog_mem_addr,
  output logic [12:0] pc,
  output logic [13:0] instr_current,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  logic [12:0] stack [0:7];
  logic [2:0]  sp;
  logic [3:0]  depth;
  logic [12:0] jump_target;
  logic [2:0]  sp_prev;

  always_comb begin
    jump_target = {pclath[4:3], instr_current[10:0]};
    sp_prev     = sp - 3'd1;
  end

  assign prog_mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= '0;
      instr_current   <= '0;
      sp              <= '0;
      depth           <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) stack[i] <= '0;
    end else begin
      if (pc_ret_en) begin
        // An empty pop still moves sp and reloads PC, exactly like the PIC.
        pc <= stack[sp_prev];
        sp <= sp_prev;
        if (depth == 4'd0) stack_underflow <= 1'b1;
        else               depth <= depth - 4'd1;
      end else if (pc_call_en) begin
        // pc already holds the return address because of prefetch.
        stack[sp] <= pc;
        sp        <= sp + 3'd1;
        pc        <= jump_target;
        if (depth == 4'd8) stack_overflow <= 1'b1;
        else               depth <= depth + 4'd1;
      end else if (pc_j_en) begin
        pc <= jump_target;
      end else if (pc_incr_en) begin
        pc <= pc + 13'd1;
      end

      if (instr_flush)      instr_current <= '0;
      else if (instr_rd_en) instr_current <= prog_mem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written stack and
// reset sequences, then randomized traffic against a behavioural model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_incr_en = 1'b0, pc_j_en = 1'b0, pc_call_en = 1'b0, pc_ret_en = 1'b0;
  logic        instr_rd_en = 1'b0, instr_flush = 1'b0;
  logic [4:0]  pclath = '0;
  logic [13:0] prog_mem_data;
  logic [12:0] prog_mem_addr, pc;
  logic [13:0] instr_current;
  logic        stack_overflow, stack_underflow;

  logic [13:0] mem [0:8191];

  assign prog_mem_data = mem[prog_mem_addr];

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
    .instr_rd_en(instr_rd_en), .instr_flush(instr_flush), .pclath(pclath),
    .prog_mem_data(prog_mem_data), .prog_mem_addr(prog_mem_addr), .pc(pc),
    .instr_current(instr_current), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit incr, j, call, ret, rd, fl;
    logic [4:0] pl;
    int e_pc, e_ir;
    bit e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: a circular array of 8 return slots plus a clamped depth.
  int m_pc, m_ir, m_top, m_cnt;
  int m_stk[8];
  bit m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit i, input bit j, input bit c, input bit r,
                       input bit rd, input bit fl, input logic [4:0] pl);
    pc_incr_en = i; pc_j_en = j; pc_call_en = c; pc_ret_en = r;
    instr_rd_en = rd; instr_flush = fl; pclath = pl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_top = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    for (int k = 0; k < 8; k++) m_stk[k] = 0;
  endtask

  task automatic model_step();
    int tgt, fetched;
    tgt     = (int'(pclath) / 8) * 2048 + (m_ir % 2048);
    fetched = int'(mem[m_pc]);
    if (pc_ret_en) begin
      m_top = (m_top + 7) % 8;
      m_pc  = m_stk[m_top];
      if (m_cnt == 0) m_unf = 1; else m_cnt--;
    end else if (pc_call_en) begin
      m_stk[m_top] = m_pc;
      m_top = (m_top + 1) % 8;
      if (m_cnt == 8) m_ovf = 1; else m_cnt++;
      m_pc = tgt;
    end else if (pc_j_en) begin
      m_pc = tgt;
    end else if (pc_incr_en) begin
      m_pc = (m_pc + 1) % 8192;
    end
    if (instr_flush) m_ir = 0;
    else if (instr_rd_en) m_ir = fetched;
  endtask

  task automatic chk_all(input string tag, input int e_pc, input int e_ir,
                         input bit e_ovf, input bit e_unf);
    chk({tag, ".pc"}, int'(pc), e_pc);
    chk({tag, ".instr"}, int'(instr_current), e_ir);
    chk({tag, ".ovf"}, int'(stack_overflow), int'(e_ovf));
    chk({tag, ".unf"}, int'(stack_underflow), int'(e_unf));
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = '0;
    mem[0]       = 14'h3005;
    mem[1]       = 14'h2923;
    mem[13'h1923] = 14'h283F;
    mem[13'h003F] = 14'h2200;

    // Directed table: fetch, GOTO with PCLATH, CALL/RETURN, empty pop.
    tbl.push_back(vec_t'{1,0,0,0,1,0,5'd0,  'h0001,'h3005,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,5'd0,  'h0001,'h3005,0,0});
    tbl.push_back(vec_t'{1,0,0,0,1,0,5'd0,  'h0002,'h2923,0,0});
    tbl.push_back(vec_t'{0,1,0,0,0,1,5'h18, 'h1923,'h0000,0,0});
    tbl.push_back(vec_t'{1,0,0,0,1,0,5'd0,  'h1924,'h283F,0,0});
    tbl.push_back(vec_t'{0,1,0,0,0,0,5'd0,  'h003F,'h283F,0,0});
    tbl.push_back(vec_t'{1,0,0,0,1,0,5'd0,  'h0040,'h2200,0,0});
    tbl.push_back(vec_t'{0,0,1,0,0,1,5'd0,  'h0200,'h0000,0,0});
    tbl.push_back(vec_t'{1,0,0,0,0,0,5'd0,  'h0201,'h0000,0,0});
    tbl.push_back(vec_t'{0,0,0,1,0,1,5'd0,  'h0040,'h0000,0,0});
    tbl.push_back(vec_t'{0,0,0,1,0,0,5'd0,  'h0000,'h0000,0,1});
    tbl.push_back(vec_t'{1,0,0,0,0,0,5'd0,  'h0001,'h0000,0,1});

    do_reset();
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.addr", int'(prog_mem_addr), 0);
    foreach (tbl[n]) begin
      drive(tbl[n].incr, tbl[n].j, tbl[n].call, tbl[n].ret, tbl[n].rd, tbl[n].fl, tbl[n].pl);
      tick();
      chk_all($sformatf("tbl%0d", n), tbl[n].e_pc, tbl[n].e_ir, tbl[n].e_ovf, tbl[n].e_unf);
    end
    chk("tbl.addr", int'(prog_mem_addr), 'h0001);

    // Nine CALLs from pc 1..9 (target 0), then nine RETURNs.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 5'd0); tick();
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 1, 0, 0, 0, 5'd0); tick();
      chk($sformatf("call%0d.ovf", k), int'(stack_overflow), (k == 9) ? 1 : 0);
      chk($sformatf("call%0d.pc", k), int'(pc), 0);
      for (int n = 0; n <= k; n++) begin
        drive(1, 0, 0, 0, 0, 0, 5'd0); tick();
      end
    end
    for (int k = 9; k >= 2; k--) begin
      drive(0, 0, 0, 1, 0, 0, 5'd0); tick();
      chk($sformatf("ret%0d.pc", k), int'(pc), k);
      chk($sformatf("ret%0d.unf", k), int'(stack_underflow), 0);
    end
    drive(0, 0, 0, 1, 0, 0, 5'd0); tick();
    chk_all("ret_last", 9, 0, 1, 1);

    // PC wrap and simultaneous return/call/increment.
    mem[0] = 14'h2FFF;
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 5'd0);  tick(); chk_all("wrap.fetch", 0, 'h2FFF, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 5'h18); tick(); chk("wrap.goto", int'(pc), 'h1FFF);
    drive(1, 0, 0, 0, 0, 0, 5'd0);  tick(); chk("wrap.incr", int'(pc), 0);
    drive(0, 0, 1, 0, 0, 0, 5'd0);  tick(); chk("wrap.call", int'(pc), 'h07FF);
    drive(1, 0, 0, 0, 0, 0, 5'd0);  tick(); chk("wrap.incr2", int'(pc), 'h0800);
    drive(1, 0, 1, 1, 0, 0, 5'd0);  tick(); chk_all("prio", 0, 'h2FFF, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 5'd0);  tick(); chk_all("prio.nopush", 0, 'h2FFF, 0, 1);

    // Flush beats read; asynchronous reset between edges.
    drive(0, 0, 0, 0, 1, 1, 5'd0);  tick(); chk("flushwins", int'(instr_current), 0);
    drive(1, 0, 0, 0, 1, 0, 5'd0);  tick(); chk_all("refetch", 1, 'h2FFF, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 5'd0);
    rst = 1'b1; #1;
    chk_all("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;

    // Reset asserted across a CALL edge discards it; next fetch from 0.
    tick();
    drive(1, 0, 1, 0, 0, 0, 5'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("rst_call", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 5'd0); tick();
    chk_all("rst_call.fetch", 1, 'h2FFF, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 5'd0); tick();
    chk_all("rst_call.empty", 0, 'h2FFF, 0, 1);

    // Randomized traffic against the model.
    for (int a = 0; a < 8192; a++) mem[a] = 14'($urandom);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        model_reset();
      end else begin
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              5'($urandom));
        model_step();
        tick();
      end
      chk_all($sformatf("rnd%0d", c), m_pc, m_ir, m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
